// File: rtl/counter_seq_pkg.sv
// Shared encodings, presets and the counter operation for counter_seq.
package counter_seq_pkg;

   localparam int unsigned CntW = 10;

   typedef enum logic [1:0] {
      ModeUp   = 2'd0,
      ModeDown = 2'd1,
      ModeShl  = 2'd2,
      ModeRsvd = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      StStop = 2'd0,
      StRun  = 2'd1,
      StStep = 2'd2
   } state_e;

   localparam logic [CntW-1:0] PresetLo  = 10'h000;
   localparam logic [CntW-1:0] PresetMid = 10'h155;
   localparam logic [CntW-1:0] PresetHi  = 10'h2AA;

   typedef struct packed {
      logic [CntW-1:0] cnt;
      logic            wrap;
   } op_res_t;

   // One counter operation; SHL never reports a wrap.
   function automatic op_res_t apply_op(input mode_e mode, input logic [CntW-1:0] cnt);
      op_res_t res;
      res.cnt  = cnt;
      res.wrap = 1'b0;
      case (mode)
         ModeUp: begin
            res.cnt  = cnt + 1'b1;
            res.wrap = &cnt;
         end
         ModeDown: begin
            res.cnt  = cnt - 1'b1;
            res.wrap = ~|cnt;
         end
         ModeShl: res.cnt = {cnt[CntW-2:0], 1'b0};
         default: ;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: pulses TICK while EN in the cycle its count is all-ones.
module tick_gen #(
   parameter int unsigned DIV_W = 23
) (
   input  logic CLK,
   input  logic RST,
   input  logic EN,
   input  logic CLR,
   output logic TICK
);

   logic [DIV_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (CLR) begin
         count_d = '0;
      end else if (EN) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign TICK = EN & (&count_q);

endmodule

// File: rtl/counter_seq.sv
// 10-bit up/down/shift counter with preset loads, single-step and prescaled free-run.
module counter_seq
   import counter_seq_pkg::*;
#(
   parameter int unsigned DIV_W = 23
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [2:0]      LOAD_REQ,
   input  logic            MODE_REQ,
   input  logic [1:0]      MODE_SEL,
   input  logic            RUN_REQ,
   input  logic            STEP_REQ,
   output logic [CntW-1:0] CNT,
   output logic [1:0]      MODE,
   output logic            RUNNING,
   output logic            TICK,
   output logic            WRAP
);

   state_e          state_q, state_d;
   mode_e           mode_q, mode_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            wrap_q, wrap_d;

   logic            tick;
   logic            load_any;
   logic            op_en;
   logic            pre_clr;
   logic [CntW-1:0] preset;
   op_res_t         op_res;

   assign load_any = |LOAD_REQ;
   // A step operates on the same edge that moves STOP into STEP.
   assign op_en    = ((state_q == StRun) && tick) ||
                     ((state_q == StStop) && STEP_REQ && !RUN_REQ);
   assign pre_clr  = load_any || ((state_q == StStop) && RUN_REQ);

   tick_gen #(
      .DIV_W (DIV_W)
   ) u_tick_gen (
      .CLK  (CLK),
      .RST  (RST),
      .EN   (state_q == StRun),
      .CLR  (pre_clr),
      .TICK (tick)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StStop;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StStop: begin
            if (RUN_REQ) begin
               state_d = StRun;
            end else if (STEP_REQ) begin
               state_d = StStep;
            end
         end
         StRun: begin
            if (RUN_REQ) begin
               state_d = StStop;
            end
         end
         StStep:  state_d = StStop;
         default: state_d = StStop;
      endcase
   end

   always_comb begin
      RUNNING = (state_q == StRun);
      CNT     = cnt_q;
      MODE    = mode_q;
      WRAP    = wrap_q;
      TICK    = tick;
   end

   always_comb begin
      if (LOAD_REQ[0]) begin
         preset = PresetLo;
      end else if (LOAD_REQ[1]) begin
         preset = PresetMid;
      end else begin
         preset = PresetHi;
      end
   end

   // Operation sees mode_q, so a coincident MODE_REQ only affects later operations.
   always_comb begin
      op_res = apply_op(mode_q, cnt_q);
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (load_any) begin
         cnt_d = preset;
      end else if (op_en) begin
         cnt_d  = op_res.cnt;
         wrap_d = op_res.wrap;
      end
   end

   always_comb begin
      mode_d = mode_q;
      if (MODE_REQ && (MODE_SEL != ModeRsvd)) begin
         mode_d = mode_e'(MODE_SEL);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q  <= '0;
         mode_q <= ModeUp;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
         wrap_q <= wrap_d;
      end
   end

endmodule
